// File: rtl/digit_scan_scheduler.sv
// Scans every board cell through the shared digit classifier and writes the
// winning digit (serial argmax over classes 1..9) or 0 into board memory.
module digit_scan_scheduler #(
    parameter int unsigned BITS    = 32,
    parameter int unsigned CELLS   = 81,
    parameter int          THRESH  = 0,
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 nn_start,
    output logic [6:0]           nn_cell,
    input  logic                 nn_done,
    input  logic [BITS*10-1:0]   layer_2,
    output logic                 wr_en,
    output logic [6:0]           wr_addr,
    output logic [3:0]           wr_digit
);

    localparam int unsigned WdW = $clog2(TIMEOUT + 1);
    localparam logic signed [BITS-1:0] Thresh = BITS'(THRESH);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StScan, StWrite, StFin} state_t;

    state_t                 state_q;
    logic [6:0]             cell_q;
    logic [3:0]             k_q;
    logic [WdW-1:0]         wdog_q;
    logic signed [BITS-1:0] score_q [1:9];
    logic signed [BITS-1:0] best_q;
    logic [3:0]             idx_q;

    logic signed [BITS-1:0] cur_score;
    logic                   take;
    logic signed [BITS-1:0] next_best;
    logic [3:0]             next_idx;
    logic                   unused_class0;

    // Class 0 (blank) never competes in the argmax.
    assign unused_class0 = ^layer_2[BITS*10-1 -: BITS];

    assign nn_cell = cell_q;
    assign wr_addr = cell_q;

    // Ties go to the later (higher) class because of >=.
    always_comb begin
        cur_score = score_q[k_q];
        take      = (k_q == 4'd1) || (cur_score >= best_q);
        next_best = take ? cur_score : best_q;
        next_idx  = take ? k_q : idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cell_q   <= '0;
            k_q      <= '0;
            wdog_q   <= '0;
            best_q   <= '0;
            idx_q    <= '0;
            for (int i = 1; i <= 9; i++) score_q[i] <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            nn_start <= 1'b0;
            wr_en    <= 1'b0;
            wr_digit <= '0;
        end else begin
            nn_start <= 1'b0;
            wr_en    <= 1'b0;
            wr_digit <= '0;
            done     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q  <= StIssue;
                        cell_q   <= '0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        nn_start <= 1'b1;
                    end
                end
                StIssue: begin
                    state_q <= StWait;
                    wdog_q  <= '0;
                end
                StWait: begin
                    if (nn_done) begin
                        for (int i = 1; i <= 9; i++) score_q[i] <= layer_2[BITS*(10-i)-1 -: BITS];
                        k_q     <= 4'd1;
                        state_q <= StScan;
                    end else if (wdog_q == WdW'(TIMEOUT - 1)) begin
                        err      <= 1'b1;
                        idx_q    <= '0;
                        wr_en    <= 1'b1;
                        state_q  <= StWrite;
                    end else begin
                        wdog_q <= wdog_q + WdW'(1);
                    end
                end
                StScan: begin
                    best_q <= next_best;
                    idx_q  <= next_idx;
                    if (k_q == 4'd9) begin
                        state_q  <= StWrite;
                        wr_en    <= 1'b1;
                        wr_digit <= (next_best < Thresh) ? 4'd0 : next_idx;
                    end else begin
                        k_q <= k_q + 4'd1;
                    end
                end
                StWrite: begin
                    if (cell_q == 7'(CELLS - 1)) begin
                        state_q <= StFin;
                        done    <= 1'b1;
                    end else begin
                        cell_q   <= cell_q + 7'd1;
                        state_q  <= StIssue;
                        nn_start <= 1'b1;
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                    cell_q  <= '0;
                    busy    <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/digit_scan_scheduler.md
Name: digit_scan_scheduler

Overview:
- Sequences the shared digit-classifier network over all 81 Sudoku cells.
- For each cell it issues one inference, captures the 10-score output vector and finds the winning digit with a serial argmax (one compare per cycle, 9 cycles).
- Writes the resulting digit, or 0 for blank/low-confidence/timeout, into the board memory.
- Sits between the top-level control FSM and the classifier/board RAM.

Parameters:
- BITS, 32: width of each signed score in layer_2.
- CELLS, 81: number of cells scanned per run.
- THRESH, 0: signed; a winning score strictly below THRESH writes digit 0.
- TIMEOUT, 4095: maximum WAIT cycles before a cell is abandoned.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a scan; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last write.
- err  output  1  sticky; set on any timeout, cleared by the next accepted start.
- nn_start  output  1  one-cycle inference request.
- nn_cell  output  7  cell index 0..CELLS-1; valid while busy.
- nn_done  input  1  classifier result valid; sampled only in WAIT.
- layer_2  input  BITS*10  scores; class k is layer_2[BITS*(10-k)-1 -: BITS]; class 0 is ignored.
- wr_en  output  1  board write strobe.
- wr_addr  output  7  board address, equal to nn_cell.
- wr_digit  output  4  digit 0..9.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; cell=0; every output 0; score register, best value/index and watchdog cleared. An in-flight inference is dropped; a later nn_done is ignored because the block is not in WAIT.
- States: IDLE, ISSUE, WAIT, SCAN, WRITE, FIN.
- IDLE: on start=1, go to ISSUE with cell=0 and err cleared.
- ISSUE: nn_start=1 for exactly one cycle, then go to WAIT with the watchdog cleared.
- WAIT:
  - nn_done=1: capture layer_2 into the score register on that edge; go to SCAN with k=1.
  - Otherwise the watchdog increments. When it reaches TIMEOUT, set err, set the best index to 0 and go directly to WRITE.
- SCAN, 9 cycles:
  - k=1 loads best=score[1], idx=1.
  - k=2..9: if score[k] >= best (signed), then best=score[k] and idx=k. Ties therefore go to the higher index.
  - After k=9, go to WRITE.
- WRITE, 1 cycle: wr_en=1, wr_addr=cell. wr_digit = 0 if timed out or if best < THRESH (signed), otherwise idx. Then:
  - cell==CELLS-1: go to FIN.
  - Otherwise: cell+1, go to ISSUE.
- FIN: done=1 for one cycle, then IDLE; cell returns to 0.
- Timing: with nn_done high at edge E, SCAN occupies cycles E+1..E+9, wr_en is high in cycle E+10 and the next nn_start is in cycle E+11. Per-cell cost = 11 + classifier latency.
- start while busy: ignored.
- nn_done outside WAIT: ignored.
- nn_done in the same cycle the watchdog hits TIMEOUT: nn_done wins (normal capture, no err).
- Scores are fully signed; the most negative value is legal.
- nn_cell and wr_addr hold their value between strobes; wr_digit is 0 when wr_en=0.

Test Plan:
- Reset, then start; the model returns score[5]=100 and all others -50 for every cell -> 81 writes, each with wr_digit=5 and addresses 0..80 in order; done pulses once; err=0.
- Cell 3 returns score[2]=score[7]=40, others 0 -> the cell 3 write has wr_digit=7 (tie goes to the higher index).
- THRESH=10; a cell returns its maximum score[9]=9 -> wr_digit=0. The same cell with score[9]=10 -> wr_digit=9.
- Model never answers for cell 0 -> nn_start, then exactly TIMEOUT WAIT cycles, then a write of addr 0 digit 0; err=1 stays set through done; the next start clears err.
- nn_done arrives 3 cycles after nn_start -> wr_en is exactly 10 cycles after the nn_done edge and the next nn_start 1 cycle later.
- rst_n low during SCAN of cell 40 -> all outputs 0 immediately. A stray nn_done afterwards produces no write. A new start restarts at cell 0.
